// File: rtl/adder_nibble_sequencer_pkg.sv
// adder_seq_pkg: shared states and field positions for the nibble-serial add sequencer
package adder_seq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, CAP, WR} state_t;
    localparam int NIB_W = 4;
    localparam int A_LSB = 0;
    localparam int B_LSB = 4;
    localparam int SUM_LSB = 0;
    function automatic int carry_bit(input int nibbles);
        return NIB_W * nibbles;
    endfunction
    function automatic int tag_lsb(input int data_width, input int tag_w);
        return data_width - tag_w;
    endfunction
endpackage

// File: rtl/adder_nibble_sequencer_if.sv
// adder_nibble_sequencer_if: input-FIFO read side and output-FIFO write side of the sequencer
interface adder_nibble_sequencer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  data_empty;
    logic                  data_rd;
    logic [DATA_WIDTH-1:0] data_din;
    logic                  data_full;
    logic                  data_wr;
    logic [DATA_WIDTH-1:0] data_dout;
    modport master (
        input  data_empty, data_din, data_full,
        output data_rd, data_wr, data_dout
    );
    modport slave (
        output data_empty, data_din, data_full,
        input  data_rd, data_wr, data_dout
    );
endinterface

// File: rtl/adder_nibble_sequencer_alu.sv
// adder_nibble_alu: combinational 4-bit add with carry-in and carry-out
module adder_nibble_alu
    import adder_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);
    assign {cout, s} = (NIB_W+1)'(a) + (NIB_W+1)'(b) + (NIB_W+1)'(cin);
endmodule

// File: rtl/adder_nibble_sequencer.sv
// adder_nibble_sequencer: pops nibble pairs LSB first, chains the carry, pushes one tagged sum word
module adder_nibble_sequencer
    import adder_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NIBBLES    = 4,
    parameter int TAG_W      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    adder_nibble_sequencer_if.master      data,
    output logic                          busy,
    output logic                          fmt_err,
    output logic [TAG_W-1:0]              op_count
);
    localparam int OW        = NIB_W * NIBBLES;
    localparam int CARRY_BIT = carry_bit(NIBBLES);
    localparam int TAG_LSB   = tag_lsb(DATA_WIDTH, TAG_W);
    localparam int CW        = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    state_t                state, state_d;
    logic [CW-1:0]         nib_cnt;
    logic                  carry, cout, last;
    logic [NIB_W-1:0]      s;
    logic [OW-1:0]         sum, sum_d;
    logic [DATA_WIDTH-1:0] dout_d;

    adder_nibble_alu u_alu (
        .a    (data.data_din[A_LSB +: NIB_W]),
        .b    (data.data_din[B_LSB +: NIB_W]),
        .cin  (carry),
        .s    (s),
        .cout (cout)
    );

    assign last         = nib_cnt == CW'(NIBBLES - 1);
    assign busy         = state != IDLE;
    assign data.data_rd = state == REQ && !data.data_empty;
    assign data.data_wr = state == WR && !data.data_full;

    always_comb begin
        state_d = state;
        sum_d = sum;
        sum_d[NIB_W*nib_cnt +: NIB_W] = s;
        dout_d = '0;
        dout_d[SUM_LSB +: OW] = sum_d;
        dout_d[CARRY_BIT] = cout;
        dout_d[TAG_LSB +: TAG_W] = op_count;
        case (state)
            IDLE:    state_d = enable ? REQ : IDLE;
            REQ:     state_d = data.data_empty ? REQ : CAP;
            CAP:     state_d = last ? WR : REQ;
            WR:      state_d = data.data_full ? WR : (enable ? REQ : IDLE);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            nib_cnt        <= '0;
            carry          <= 1'b0;
            sum            <= '0;
            data.data_dout <= '0;
            fmt_err        <= 1'b0;
            op_count       <= '0;
        end else begin
            state <= state_d;
            // every operation starts from nibble 0 with a zero carry-in
            if ((state == IDLE && enable) || data.data_wr) begin
                nib_cnt <= '0;
                carry   <= 1'b0;
                sum     <= '0;
            end
            if (state == CAP) begin
                sum     <= sum_d;
                carry   <= cout;
                fmt_err <= fmt_err | (|data.data_din[DATA_WIDTH-1:8]);
                if (last) data.data_dout <= dout_d;
                else nib_cnt <= nib_cnt + CW'(1);
            end
            if (data.data_wr) op_count <= op_count + TAG_W'(1);
        end
    end
endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// tb_adder_nibble_sequencer: directed vectors and corner sequences against hand-computed results
module tb_adder_nibble_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       busy, fmt_err;
    logic [7:0] op_count;

    adder_nibble_sequencer_if #(.DATA_WIDTH(32)) bus ();

    adder_nibble_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .data     (bus),
        .busy     (busy),
        .fmt_err  (fmt_err),
        .op_count (op_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] fifo[$];
    logic        hold_full = 1'b0;
    int          cyc = 0, pops = 0, wr_cnt = 0, wr_cyc = 0, viol = 0;
    int          total = 0, passed = 0;
    logic [31:0] last_dout = '0, cur_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic upd();
        bus.data_empty = fifo.size() == 0;
        bus.data_full  = hold_full;
    endtask

    task automatic step();
        logic rd, wr;
        @(negedge clock);
        rd = bus.data_rd;
        wr = bus.data_wr;
        cur_dout = bus.data_dout;
        if ((rd && wr) || (rd && bus.data_empty) || (wr && bus.data_full)) viol++;
        if (wr) begin
            wr_cnt++;
            wr_cyc = cyc;
            last_dout = bus.data_dout;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (rd) begin
            bus.data_din = fifo.pop_front();
            pops++;
        end
        upd();
    endtask

    function automatic logic [3:0][31:0] build(input logic [15:0] a, input logic [15:0] b);
        logic [3:0][31:0] w;
        for (int i = 0; i < 4; i++) w[i] = {24'h0, b[4*i +: 4], a[4*i +: 4]};
        return w;
    endfunction

    task automatic run_op(input logic [3:0][31:0] words, input int stall, output logic [31:0] dout);
        int p0, wr0, n, ps;
        p0 = pops;
        wr0 = wr_cnt;
        for (int i = 0; i < 4; i++) if (stall == 0 || i < 2) fifo.push_back(words[i]);
        upd();
        if (stall > 0) begin
            n = 0;
            while (pops - p0 < 2 && n < 100) begin step(); n++; end
            check("stall_pre_pops", 32'(pops - p0), 32'd2);
            ps = pops;
            repeat (stall) step();
            check("stall_no_rd", 32'(pops - ps), 32'd0);
            for (int i = 2; i < 4; i++) fifo.push_back(words[i]);
            upd();
        end
        n = 0;
        while (wr_cnt == wr0 && n < 200) begin step(); n++; end
        if (wr_cnt == wr0) check("op_timeout", 32'(wr_cnt - wr0), 32'd1);
        dout = last_dout;
    endtask

    initial begin
        vec_t             vecs[7];
        logic [31:0]      d;
        logic [3:0][31:0] w;
        int               t0, prev, wr0, p0, n;
        vecs[0] = '{16'h0F35, 16'hACF0, 32'h0000BC25};
        vecs[1] = '{16'hFFFF, 16'h0001, 32'h01010000};
        vecs[2] = '{16'h8000, 16'h8000, 32'h02010000};
        vecs[3] = '{16'h0000, 16'h0000, 32'h03000000};
        vecs[4] = '{16'h1234, 16'h4321, 32'h04005555};
        vecs[5] = '{16'h7FFF, 16'h0001, 32'h05008000};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 32'h0601FFFE};
        bus.data_din = '0;
        upd();
        repeat (2) step();
        reset = 1'b0;
        check("rst_dout", bus.data_dout, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fmt_err", 32'(fmt_err), 32'h0);
        check("rst_op_count", 32'(op_count), 32'h0);
        check("rst_rd_wr", {30'h0, bus.data_rd, bus.data_wr}, 32'h0);

        enable = 1'b1;
        t0 = cyc;
        prev = 0;
        for (int i = 0; i < 7; i++) begin
            run_op(build(vecs[i].a, vecs[i].b), 0, d);
            check($sformatf("vec%0d_dout", i), d, vecs[i].exp);
            check($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(i + 1));
            if (i == 0) check("first_latency", 32'(wr_cyc - t0), 32'd9);
            if (i == 1) check("b2b_interval", 32'(wr_cyc - prev), 32'd9);
            prev = wr_cyc;
        end

        run_op(build(16'h1234, 16'h1111), 5, d);
        check("stall_dout", d, 32'h07002345);

        // state is REQ here: 8 cycles reach WR, then 6 more held full
        hold_full = 1'b1;
        wr0 = wr_cnt;
        w = build(16'hA5A5, 16'h5A5A);
        for (int i = 0; i < 4; i++) fifo.push_back(w[i]);
        upd();
        repeat (9) step();
        check("full_dout_entry", cur_dout, 32'h0800FFFF);
        repeat (5) step();
        check("full_dout_held", cur_dout, 32'h0800FFFF);
        check("full_no_wr", 32'(wr_cnt - wr0), 32'd0);
        enable = 1'b0;
        hold_full = 1'b0;
        upd();
        repeat (4) step();
        check("full_single_wr", 32'(wr_cnt - wr0), 32'd1);
        check("full_wr_dout", last_dout, 32'h0800FFFF);
        check("idle_after_disable", 32'(busy), 32'h0);

        enable = 1'b1;
        w = build(16'h0000, 16'h0000);
        w[0] = 32'h00000155;
        run_op(w, 0, d);
        check("fmt_dout", d, 32'h0900000A);
        check("fmt_err_set", 32'(fmt_err), 32'h1);
        run_op(build(16'h0001, 16'h0001), 0, d);
        check("fmt_next_dout", d, 32'h0A000002);
        check("fmt_err_sticky", 32'(fmt_err), 32'h1);

        p0 = pops;
        wr0 = wr_cnt;
        w = build(16'h1111, 16'h2222);
        for (int i = 0; i < 4; i++) fifo.push_back(w[i]);
        upd();
        n = 0;
        while (pops - p0 < 2 && n < 100) begin step(); n++; end
        enable = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        fifo.delete();
        upd();
        check("mid_rst_dout", bus.data_dout, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_fmt_err", 32'(fmt_err), 32'h0);
        check("mid_rst_op_count", 32'(op_count), 32'h0);
        repeat (3) step();
        check("mid_rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
        enable = 1'b1;
        run_op(build(16'h0F35, 16'hACF0), 0, d);
        check("post_rst_dout", d, 32'h0000BC25);
        check("post_rst_op_count", 32'(op_count), 32'h1);

        for (int i = 0; i < 254; i++) run_op(build(16'h0000, 16'h0000), 0, d);
        check("pre_wrap_op_count", 32'(op_count), 32'hFF);
        run_op(build(16'h0001, 16'h0002), 0, d);
        check("wrap_tag_dout", d, 32'hFF000003);
        check("wrap_op_count", 32'(op_count), 32'h0);
        run_op(build(16'h0001, 16'h0002), 0, d);
        check("after_wrap_dout", d, 32'h00000003);

        check("protocol_violations", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adder_nibble_sequencer.md
Name: adder_nibble_sequencer

Overview:
- Controller that drives a nibble-serial add of two multi-nibble operands between the input FIFO and the output FIFO of the user CL adder path.
- Pops NIBBLES operand-pair words from the input FIFO, LSB nibble first, and chains the carry across them.
- Assembles the sum plus carry-out and pushes one tagged result word to the output FIFO.
- Sits between the CL input/output FIFOs and replaces free-running adder sequencing with an explicit read/accumulate/write FSM.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must be ≥ 32.
- NIBBLES, 4, nibble pairs per operation; operand width is 4*NIBBLES = 16.
- TAG_W, 8, width of the operation tag in the result word.

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; allows new operations to start
- data_empty  in  1  input FIFO empty
- data_rd  out  1  input FIFO read strobe
- data_din  in  DATA_WIDTH  input FIFO word: [3:0]=A nibble, [7:4]=B nibble, [DATA_WIDTH-1:8] must be 0
- data_full  in  1  output FIFO full
- data_wr  out  1  output FIFO write strobe
- data_dout  out  DATA_WIDTH  result word
- busy  out  1  operation in progress (state≠IDLE)
- fmt_err  out  1  sticky: a popped word had nonzero bits [DATA_WIDTH-1:8]
- op_count  out  TAG_W  completed operations, wraps modulo 2^TAG_W

Behaviour:
- Reset (synchronous, active-high, clock edge): state=IDLE; data_rd=0, data_wr=0, data_dout=0, busy=0, fmt_err=0, op_count=0; nib_cnt, carry, sum cleared.
- FIFO read model: non-FWFT. data_din is valid in the cycle after a one-cycle data_rd pulse.
- data_rd is asserted only in REQ and only when data_empty=0.
- State IDLE:
  - enable=1 → REQ; clear nib_cnt, carry, sum.
  - enable=0 → stay in IDLE.
- State REQ:
  - data_empty=0 → data_rd=1 for this cycle, go to CAP.
  - data_empty=1 → data_rd=0, stay in REQ. Waits indefinitely.
- State CAP (data_din valid):
  - {c,s} = A + B + carry (5-bit result).
  - sum[4*nib_cnt +: 4] = s; carry = c.
  - fmt_err |= (data_din[DATA_WIDTH-1:8] ≠ 0); upper bits are otherwise ignored.
  - nib_cnt == NIBBLES-1 → load data_dout, go to WR. Otherwise nib_cnt++, go to REQ.
- State WR:
  - data_dout = {op_count[TAG_W-1:0], zeros, carry at bit 4*NIBBLES, sum[4*NIBBLES-1:0]}. Registered and held stable for the whole of WR.
  - data_wr = 1 only in a WR cycle with data_full=0. Exactly one pulse per operation.
  - On that cycle: op_count++, then go to REQ if enable=1, else IDLE.
  - data_full=1 → data_wr=0, stay in WR.
- data_wr and data_rd are never both high in the same cycle.
- Minimum latency: 2*NIBBLES+1 cycles from leaving IDLE to data_wr (9 for defaults). Back-to-back operations with enable=1: one result every 2*NIBBLES+1 cycles.
- enable deasserted mid-operation: the current operation completes, including its write; no new operation starts.
- Reset mid-operation: partial sum discarded, no write issued, nibbles already popped are lost.
- op_count wraps 255→0. Tag is the pre-increment value.
- Carry-in of the first nibble is always 0.
- busy = (state ≠ IDLE), registered.

Decomposition:
- Package adder_seq_pkg holds:
  - state enum {IDLE, REQ, CAP, WR}
  - constant NIB_W=4
  - result field positions: SUM_LSB=0, CARRY_BIT=4*NIBBLES, TAG_LSB=DATA_WIDTH-TAG_W
  - input field positions: A_LSB=0, B_LSB=4
- Sub-module adder_nibble_alu: combinational 4-bit A+B+cin → {cout, s}. Instantiated once. Everything else stays in the top FSM.

Test Plan:
- enable=1; feed (A,B) LSB-first (5,0),(3,F),(F,C),(0,A), i.e. 0x0F35+0xACF0 → one data_wr, data_dout=0x0000BC25, op_count=1.
- Second operation 0xFFFF+0x0001: nibbles (F,1),(F,0),(F,0),(F,0) → data_dout=0x01010000 (tag 1, carry 1, sum 0).
- data_empty=1 for 5 cycles between the 2nd and 3rd nibbles of 0x1234+0x1111 → data_rd stays 0 during the stall; result 0x00002345 with tag=current op_count.
- data_full=1 for 6 cycles on entry to WR → data_wr=0 and data_dout stable throughout; single data_wr pulse when full drops.
- Reset pulse after 2 nibbles popped → all outputs 0 next cycle, no data_wr; a subsequent full operation gives the correct sum with tag 0.
- Word 0x00000155 popped → fmt_err=1 and stays set until reset; sum nibble 0xA is still used. Also run 256 operations and check tag wrap 0xFF→0x00.
